// File: rtl/fp_exc_pkg.sv
// Shared types for the FPU front-end operand classifier: exception codes,
// handshake FSM states and sticky-flag bit positions.
package fp_exc_pkg;

  typedef enum logic [2:0] {
    EXC_NORMAL    = 3'd0,
    EXC_ZERO      = 3'd1,
    EXC_SUBNORMAL = 3'd2,
    EXC_INF       = 3'd3,
    EXC_QNAN      = 3'd4,
    EXC_SNAN      = 3'd5
  } ExcCode;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ClsState;

  localparam int STK_SUB  = 0;
  localparam int STK_INF  = 1;
  localparam int STK_QNAN = 2;
  localparam int STK_SNAN = 3;

  // Zero and normal operands never raise a sticky flag.
  function automatic logic [3:0] sticky_mask(input ExcCode c);
    logic [3:0] m;
    m = '0;
    case (c)
      EXC_SUBNORMAL: m[STK_SUB]  = 1'b1;
      EXC_INF:       m[STK_INF]  = 1'b1;
      EXC_QNAN:      m[STK_QNAN] = 1'b1;
      EXC_SNAN:      m[STK_SNAN] = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand classifier: splits the operand into its
// fields and maps them to a single exception code plus the sign bit.
module fp_classify
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] data,
  output ExcCode               exc,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = data[EXP_W+MAN_W];
  assign exp_f = data[EXP_W+MAN_W-1:MAN_W];
  assign man_f = data[MAN_W-1:0];

  // The fraction MSB is the quiet bit; an all-ones exponent with a nonzero
  // fraction and a clear quiet bit is a signalling NaN.
  always_comb begin
    exc = EXC_NORMAL;
    if (exp_f == '0) begin
      if (man_f == '0) exc = EXC_ZERO;
      else             exc = EXC_SUBNORMAL;
    end else if (&exp_f) begin
      if (man_f == '0)         exc = EXC_INF;
      else if (man_f[MAN_W-1]) exc = EXC_QNAN;
      else                     exc = EXC_SNAN;
    end
  end

endmodule

// File: rtl/fp_exception_classifier.sv
// FPU front-end operand classifier: one-deep valid/ready result register with
// full throughput, plus sticky per-class flags for status readout.
module fp_exception_classifier
  import fp_exc_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [EXP_W+MAN_W:0] Data,
  input  logic                 Data_valid,
  output logic                 Data_ready,
  output logic [2:0]           Exc,
  output logic                 Sign,
  output logic                 Exc_valid,
  input  logic                 Exc_ready,
  output logic [3:0]           Sticky,
  input  logic                 Sticky_clr
);

  ClsState    state, state_n;
  ExcCode     cls_p0, exc_p1;
  logic       sign_p0, sign_p1;
  logic [3:0] sticky_p1, sticky_n;
  logic       accept;

  // Stage p0: combinational classification of the offered operand
  fp_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .data (Data),
    .exc  (cls_p0),
    .sign (sign_p0)
  );

  assign accept = Data_valid & Data_ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (accept) state_n = FULL;
      FULL:    if (Exc_ready && !accept) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_comb begin
    Data_ready = (state == EMPTY) | Exc_ready;
    Exc_valid  = (state == FULL);
  end

  // Clear takes effect before the newly accepted operand ORs in its flag.
  always_comb begin
    sticky_n = Sticky_clr ? 4'b0000 : sticky_p1;
    if (accept) sticky_n = sticky_n | sticky_mask(cls_p0);
  end

  // Stage p1: held result and sticky flags; only reloaded on acceptance
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      exc_p1    <= EXC_NORMAL;
      sign_p1   <= 1'b0;
      sticky_p1 <= 4'b0000;
    end else begin
      sticky_p1 <= sticky_n;
      if (accept) begin
        exc_p1  <= cls_p0;
        sign_p1 <= sign_p0;
      end
    end
  end

  assign Exc    = exc_p1;
  assign Sign   = sign_p1;
  assign Sticky = sticky_p1;

endmodule

// File: tb/tb_fp_exception_classifier.sv
// Self-checking bench for fp_exception_classifier: directed scenarios plus
// randomized traffic compared against a field-arithmetic reference model.
module tb_fp_exception_classifier;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] Data;
  logic        Data_valid, Data_ready, Sign, Exc_valid, Exc_ready, Sticky_clr;
  logic [2:0]  Exc;
  logic [3:0]  Sticky;

  logic [15:0] h_data;
  logic        h_valid, h_ready_o, h_sign, h_exc_valid, h_exc_ready, h_clr;
  logic [2:0]  h_exc;
  logic [3:0]  h_sticky;

  int nchk = 0;
  int nfail = 0;

  // Reference model state: a one-entry queue of held results.
  logic [2:0] held_exc[$];
  logic       held_sign[$];
  logic [2:0] m_exc;
  logic       m_sign;
  logic [3:0] m_sticky;
  logic       m_ready;

  always #5 CLK = ~CLK;

  fp_exception_classifier dut (
    .CLK(CLK), .RSTN(RSTN), .Data(Data), .Data_valid(Data_valid),
    .Data_ready(Data_ready), .Exc(Exc), .Sign(Sign), .Exc_valid(Exc_valid),
    .Exc_ready(Exc_ready), .Sticky(Sticky), .Sticky_clr(Sticky_clr)
  );

  fp_exception_classifier #(.EXP_W(5), .MAN_W(10)) dut_h (
    .CLK(CLK), .RSTN(RSTN), .Data(h_data), .Data_valid(h_valid),
    .Data_ready(h_ready_o), .Exc(h_exc), .Sign(h_sign), .Exc_valid(h_exc_valid),
    .Exc_ready(h_exc_ready), .Sticky(h_sticky), .Sticky_clr(h_clr)
  );

  function automatic logic [2:0] ref_class(input longint unsigned d, input int ew, input int mw);
    longint unsigned e, m, ones;
    ones = (64'd1 << ew) - 1;
    e = (d >> mw) & ones;
    m = d & ((64'd1 << mw) - 1);
    if (e == 0) return (m == 0) ? 3'd1 : 3'd2;
    if (e == ones) begin
      if (m == 0) return 3'd3;
      if (m >= (64'd1 << (mw - 1))) return 3'd4;
      return 3'd5;
    end
    return 3'd0;
  endfunction

  function automatic logic [3:0] ref_flag(input logic [2:0] code);
    case (code)
      3'd5:    return 4'b1000;
      3'd4:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd2:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    held_exc.delete();
    held_sign.delete();
    m_exc = 3'd0;
    m_sign = 1'b0;
    m_sticky = 4'b0;
    m_ready = 1'b1;
  endtask

  task automatic set_inputs(input logic [31:0] d, input logic v, input logic r, input logic c);
    Data = d; Data_valid = v; Exc_ready = r; Sticky_clr = c;
    m_ready = (held_exc.size() == 0) || r;
    #1;
  endtask

  // Advance one clock and update the model from the inputs applied before it.
  task automatic tick();
    logic acc;
    logic [2:0] code;
    acc = Data_valid && m_ready;
    code = ref_class({32'd0, Data}, 8, 23);
    if (Exc_ready && held_exc.size() != 0) begin
      void'(held_exc.pop_front());
      void'(held_sign.pop_front());
    end
    if (acc) begin
      held_exc.push_back(code);
      held_sign.push_back(Data[31]);
      m_exc = code;
      m_sign = Data[31];
    end
    if (Sticky_clr) m_sticky = 4'b0;
    if (acc) m_sticky = m_sticky | ref_flag(code);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    Data = '0; Data_valid = 0; Exc_ready = 0; Sticky_clr = 0;
    h_data = '0; h_valid = 0; h_exc_ready = 1; h_clr = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    nchk++; if (Exc !== 3'd0) begin nfail++; $display("FAIL reset_exc got=%0d exp=0", Exc); end
    nchk++; if (Sign !== 1'b0) begin nfail++; $display("FAIL reset_sign got=%0d exp=0", Sign); end
    nchk++; if (Exc_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got=%0d exp=0", Exc_valid); end
    nchk++; if (Sticky !== 4'b0) begin nfail++; $display("FAIL reset_sticky got=%b exp=0000", Sticky); end
    nchk++; if (Data_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got=%0d exp=1", Data_ready); end
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_inf();
    set_inputs(32'h7F800000, 1, 1, 0);
    tick();
    set_inputs(32'h0, 0, 0, 0);
    nchk++; if (Exc !== 3'b011) begin nfail++; $display("FAIL inf_exc got=%b exp=011", Exc); end
    nchk++; if (Sign !== 1'b0) begin nfail++; $display("FAIL inf_sign got=%0d exp=0", Sign); end
    nchk++; if (Exc_valid !== 1'b1) begin nfail++; $display("FAIL inf_valid got=%0d exp=1", Exc_valid); end
    nchk++; if (Sticky !== 4'b0010) begin nfail++; $display("FAIL inf_sticky got=%b exp=0010", Sticky); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [4];
    logic [2:0]  codes [4];
    ops = '{32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h80000000};
    codes = '{3'b100, 3'b101, 3'b010, 3'b001};
    set_inputs(32'h0, 0, 1, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_inputs(ops[i], 1, 1, 0);
      nchk++; if (Data_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready[%0d] got=%0d exp=1", i, Data_ready); end
      tick();
      nchk++; if (Exc !== codes[i] || Exc_valid !== 1'b1) begin
        nfail++; $display("FAIL b2b_exc[%0d] got=%b/v%0d exp=%b/v1", i, Exc, Exc_valid, codes[i]);
      end
    end
    set_inputs(32'h0, 0, 1, 0);
    nchk++; if (Sign !== 1'b1) begin nfail++; $display("FAIL b2b_sign got=%0d exp=1", Sign); end
    nchk++; if (Sticky !== 4'b1101) begin nfail++; $display("FAIL b2b_sticky got=%b exp=1101", Sticky); end
    tick();
    nchk++; if (Exc_valid !== 1'b0) begin nfail++; $display("FAIL b2b_drain got=%0d exp=0", Exc_valid); end
  endtask

  task automatic test_backpressure();
    set_inputs(32'h3F800000, 1, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_inputs(32'hFF800000, 1, 0, 0);
      nchk++; if (Data_ready !== 1'b0) begin nfail++; $display("FAIL bp_ready[%0d] got=%0d exp=0", i, Data_ready); end
      tick();
      nchk++; if (Exc !== 3'b000 || Sign !== 1'b0 || Exc_valid !== 1'b1) begin
        nfail++; $display("FAIL bp_hold[%0d] got=%b/s%0d/v%0d exp=000/s0/v1", i, Exc, Sign, Exc_valid);
      end
    end
    set_inputs(32'hFF800000, 1, 1, 0);
    nchk++; if (Data_ready !== 1'b1) begin nfail++; $display("FAIL bp_release_ready got=%0d exp=1", Data_ready); end
    tick();
    nchk++; if (Exc !== 3'b011 || Sign !== 1'b1 || Exc_valid !== 1'b1) begin
      nfail++; $display("FAIL bp_release got=%b/s%0d/v%0d exp=011/s1/v1", Exc, Sign, Exc_valid);
    end
  endtask

  task automatic test_sticky_clr();
    nchk++; if (Sticky === 4'b0000) begin nfail++; $display("FAIL clr_precond got=%b exp=nonzero", Sticky); end
    set_inputs(32'h7F800001, 1, 1, 1);
    tick();
    set_inputs(32'h0, 0, 1, 0);
    nchk++; if (Sticky !== 4'b1000) begin nfail++; $display("FAIL clr_same_cycle got=%b exp=1000", Sticky); end
    nchk++; if (Exc !== 3'b101) begin nfail++; $display("FAIL clr_exc got=%b exp=101", Exc); end
    tick();
  endtask

  task automatic test_half();
    logic [15:0] hops [4];
    logic [2:0]  hcodes [4];
    hops = '{16'h7C00, 16'h7E00, 16'h0000, 16'h3C00};
    hcodes = '{3'b011, 3'b100, 3'b001, 3'b000};
    for (int i = 0; i < 4; i++) begin
      h_data = hops[i]; h_valid = 1'b1;
      set_inputs(32'h0, 0, 1, 0);
      tick();
      nchk++; if (h_exc !== hcodes[i] || h_exc !== ref_class({48'd0, hops[i]}, 5, 10) || h_exc_valid !== 1'b1) begin
        nfail++; $display("FAIL half[%0d] got=%b/v%0d exp=%b/v1", i, h_exc, h_exc_valid, hcodes[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      h_data = 16'($urandom);
      if ($urandom_range(1) == 0) h_data[14:10] = 5'h1F;
      tick();
      nchk++; if (h_exc !== ref_class({48'd0, h_data}, 5, 10)) begin
        nfail++; $display("FAIL half_rand data=%h got=%b exp=%b", h_data, h_exc, ref_class({48'd0, h_data}, 5, 10));
      end
    end
    h_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic v, r, c, stall;
    d = 32'h0; v = 0;
    for (int i = 0; i < 300; i++) begin
      stall = Data_valid && !Data_ready;
      if (!stall) begin
        d = $urandom;
        case ($urandom_range(3))
          0: d[30:23] = 8'h00;
          1: d[30:23] = 8'hFF;
          default: ;
        endcase
        if ($urandom_range(3) == 0) d[22:0] = '0;
        if ($urandom_range(3) == 0) d[22] = ~d[22];
        v = ($urandom_range(3) != 0);
      end
      r = ($urandom_range(2) != 0);
      c = ($urandom_range(15) == 0);
      set_inputs(d, v, r, c);
      nchk++; if (Data_ready !== m_ready) begin nfail++; $display("FAIL rand_ready[%0d] got=%0d exp=%0d", i, Data_ready, m_ready); end
      tick();
      nchk++; if (Exc_valid !== (held_exc.size() != 0)) begin
        nfail++; $display("FAIL rand_valid[%0d] got=%0d exp=%0d", i, Exc_valid, held_exc.size() != 0);
      end
      nchk++; if (Exc !== m_exc || Sign !== m_sign) begin
        nfail++; $display("FAIL rand_exc[%0d] got=%b/s%0d exp=%b/s%0d", i, Exc, Sign, m_exc, m_sign);
      end
      nchk++; if (Sticky !== m_sticky) begin nfail++; $display("FAIL rand_sticky[%0d] got=%b exp=%b", i, Sticky, m_sticky); end
    end
  endtask

  task automatic test_reset_mid();
    set_inputs(32'h7F800000, 1, 1, 0);
    tick();
    set_inputs(32'h0, 0, 0, 0);
    nchk++; if (Exc_valid !== 1'b1) begin nfail++; $display("FAIL rmid_precond got=%0d exp=1", Exc_valid); end
    RSTN = 1'b0;
    #1;
    nchk++; if (Exc_valid !== 1'b0) begin nfail++; $display("FAIL rmid_valid got=%0d exp=0", Exc_valid); end
    nchk++; if (Sticky !== 4'b0) begin nfail++; $display("FAIL rmid_sticky got=%b exp=0000", Sticky); end
    model_reset();
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_inputs(32'h0, 0, 0, 0);
      tick();
      nchk++; if (Exc_valid !== 1'b0) begin nfail++; $display("FAIL rmid_idle[%0d] got=%0d exp=0", i, Exc_valid); end
    end
    set_inputs(32'h00400000, 1, 0, 0);
    nchk++; if (Data_ready !== 1'b1) begin nfail++; $display("FAIL rmid_ready got=%0d exp=1", Data_ready); end
    tick();
    nchk++; if (Exc_valid !== 1'b1 || Exc !== 3'b010) begin
      nfail++; $display("FAIL rmid_first got=%b/v%0d exp=010/v1", Exc, Exc_valid);
    end
  endtask

  initial begin
    test_reset();
    test_inf();
    test_back_to_back();
    test_backpressure();
    test_sticky_clr();
    test_half();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
